// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I pipeline types for the memory/writeback slice
package rv32i_types;

    localparam int XLEN = 32;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [3:0] {
        rf_alu_out  = 4'd0,
        rf_br_en    = 4'd1,
        rf_u_imm    = 4'd2,
        rf_lw       = 4'd3,
        rf_pc_plus4 = 4'd4,
        rf_lb       = 4'd5,
        rf_lbu      = 4'd6,
        rf_lh       = 4'd7,
        rf_lhu      = 4'd8
    } regfilemux_sel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_fsm_state_t;

    typedef struct packed {
        rv32i_opcode     opcode;
        logic [2:0]      funct3;
        regfilemux_sel_t regfilemux_sel;
        logic [4:0]      rd;
        logic [31:0]     pc;
    } rv32i_control_word;

    typedef struct packed {
        logic [31:0] i_imm;
        logic [31:0] s_imm;
        logic [31:0] b_imm;
        logic [31:0] u_imm;
        logic [31:0] j_imm;
    } packed_imm;

    typedef struct packed {
        logic        commit;
        logic [63:0] order;
        logic [31:0] inst;
        logic        trap;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } monitor_t;

    function automatic logic writes_rd(rv32i_opcode op);
        case (op)
            op_lui, op_auipc, op_jal, op_jalr, op_load, op_imm, op_reg: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane store shift/mask and load extract/extend, shared with the monitor checker
module mem_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_mask,
    output logic [31:0] store_shifted,
    output logic [31:0] load_value,
    output logic        misaligned
);

    logic [31:0] shifted_word;

    assign shifted_word = load_word >> {offset, 3'b000};

    // funct3[1:0] encodes the access size for both loads and stores
    always_comb begin
        byte_mask     = 4'b1111;
        store_shifted = store_data;
        misaligned    = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                byte_mask     = 4'b0001 << offset;
                store_shifted = store_data << {offset, 3'b000};
            end
            2'b01: begin
                byte_mask     = 4'b0011 << {offset[1], 1'b0};
                store_shifted = store_data << {offset[1], 4'b0000};
                misaligned    = offset[0];
            end
            default: begin
                misaligned    = |offset;
            end
        endcase
    end

    always_comb begin
        case (load_funct3_t'(funct3))
            lb:      load_value = {{24{shifted_word[7]}}, shifted_word[7:0]};
            lbu:     load_value = {24'b0, shifted_word[7:0]};
            lh:      load_value = {{16{shifted_word[15]}}, shifted_word[15:0]};
            lhu:     load_value = {16'b0, shifted_word[15:0]};
            default: load_value = load_word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - data-memory access FSM plus MEM/WB register; MISALIGN_TRAP_EN enables misaligned-access traps
module mem_wb_stage
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  rv32i_control_word control_word_in,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       mar_in,
    input  logic [31:0]       mem_wdata_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              br_en_in,
    input  packed_imm         imm_in,
    input  monitor_t          monitor_in,
    input  logic              dmem_resp,
    input  logic [31:0]       dmem_rdata,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [31:0]       dmem_address,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_byte_enable,
    output logic              mem_stall,
    output logic              load_regfile,
    output logic [4:0]        rd_out,
    output logic [31:0]       regfile_wdata,
    output monitor_t          monitor_out
);

`ifdef MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    mem_fsm_state_t state, state_next;
    logic [31:0]    rdata_hold;
    logic [31:0]    load_word;
    logic [3:0]     byte_mask;
    logic [31:0]    store_shifted;
    logic [31:0]    load_value;
    logic           misaligned;
    logic           trap;
    logic           mem_req;
    logic [31:0]    wb_data;
    logic           wb_en;
    logic [4:0]     rd_q;
    monitor_t       mon_next;

    // A response on the same cycle as load bypasses rdata_hold
    assign load_word = (state == ACCESS) ? dmem_rdata : rdata_hold;

    mem_align u_align (
        .funct3        (control_word_in.funct3),
        .offset        (mar_in[1:0]),
        .store_data    (mem_wdata_in),
        .load_word     (load_word),
        .byte_mask     (byte_mask),
        .store_shifted (store_shifted),
        .load_value    (load_value),
        .misaligned    (misaligned)
    );

    assign trap    = TRAP_EN & (mem_read_in | mem_write_in) & misaligned;
    assign mem_req = (mem_read_in | mem_write_in) & ~trap;

    assign dmem_address     = {mar_in[31:2], 2'b00};
    assign dmem_wdata       = store_shifted;
    assign dmem_byte_enable = mem_write_in ? byte_mask : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes drop in the response cycle so strobe and stall span the same cycles
    always_comb begin
        state_next = state;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        mem_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    dmem_read  = mem_read_in;
                    dmem_write = mem_write_in;
                    mem_stall  = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (dmem_resp) begin
                    state_next = load ? IDLE : DONE;
                end else begin
                    dmem_read  = mem_read_in;
                    dmem_write = mem_write_in;
                    mem_stall  = 1'b1;
                end
            end
            DONE: begin
                if (load) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            dmem_read  = 1'b0;
            dmem_write = 1'b0;
            mem_stall  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_hold <= 32'b0;
        end else if (state == ACCESS && dmem_resp) begin
            rdata_hold <= dmem_rdata;
        end
    end

    always_comb begin
        case (control_word_in.regfilemux_sel)
            rf_alu_out:  wb_data = alu_in;
            rf_br_en:    wb_data = {31'b0, br_en_in};
            rf_u_imm:    wb_data = imm_in.u_imm;
            rf_pc_plus4: wb_data = control_word_in.pc + 32'd4;
            rf_lw, rf_lb, rf_lbu, rf_lh, rf_lhu: wb_data = load_value;
            default:     wb_data = alu_in;
        endcase
    end

    assign wb_en = monitor_in.commit & (control_word_in.rd != 5'd0)
                 & writes_rd(control_word_in.opcode) & ~trap;

    always_comb begin
        mon_next           = monitor_in;
        mon_next.trap      = monitor_in.trap | trap;
        mon_next.mem_addr  = mar_in;
        mon_next.mem_rmask = (mem_req & mem_read_in)  ? byte_mask     : 4'b0;
        mon_next.mem_wmask = (mem_req & mem_write_in) ? byte_mask     : 4'b0;
        mon_next.mem_rdata = (mem_req & mem_read_in)  ? load_word     : 32'b0;
        mon_next.mem_wdata = (mem_req & mem_write_in) ? store_shifted : 32'b0;
        mon_next.rd_wdata  = (control_word_in.rd == 5'd0) ? 32'b0 : wb_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q          <= 5'd0;
            load_regfile  <= 1'b0;
            regfile_wdata <= 32'b0;
            monitor_out   <= '0;
        end else if (load && !mem_stall) begin
            if (bubble) begin
                rd_q                <= 5'd0;
                load_regfile        <= 1'b0;
                monitor_out.commit  <= 1'b0;
                monitor_out.rd_addr <= 5'd0;
            end else begin
                rd_q          <= control_word_in.rd;
                load_regfile  <= wb_en;
                regfile_wdata <= wb_data;
                monitor_out   <= mon_next;
            end
        end
    end

    assign rd_out = rd_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
    import rv32i_types::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              load;
    logic              bubble;
    rv32i_control_word control_word_in;
    logic [31:0]       alu_in, mar_in, mem_wdata_in;
    logic              mem_read_in, mem_write_in, br_en_in;
    packed_imm         imm_in;
    monitor_t          monitor_in;
    logic              dmem_resp;
    logic [31:0]       dmem_rdata;
    logic              dmem_read, dmem_write;
    logic [31:0]       dmem_address, dmem_wdata;
    logic [3:0]        dmem_byte_enable;
    logic              mem_stall, load_regfile;
    logic [4:0]        rd_out;
    logic [31:0]       regfile_wdata;
    monitor_t          monitor_out;

    int checks = 0;
    int errors = 0;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .load(load), .bubble(bubble),
        .control_word_in(control_word_in), .alu_in(alu_in), .mar_in(mar_in),
        .mem_wdata_in(mem_wdata_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .br_en_in(br_en_in), .imm_in(imm_in), .monitor_in(monitor_in),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
        .mem_stall(mem_stall), .load_regfile(load_regfile), .rd_out(rd_out),
        .regfile_wdata(regfile_wdata), .monitor_out(monitor_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        rv32i_opcode     opc;
        logic [2:0]      f3;
        regfilemux_sel_t sel;
        logic [4:0]      rd;
        logic            commit;
        logic [31:0]     mar, rs2, rdata, alu, uimm, pc;
        logic            br;
        int              lat;
        int              hold;
    } instr_t;

    // ---------------- reference model ----------------
    function automatic bit is_mem(instr_t t);
        return t.commit && (t.opc == op_load || t.opc == op_store);
    endfunction

    function automatic int ref_size(instr_t t);
        if (t.f3[1:0] == 2'b00) return 1;
        if (t.f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int ref_pos(instr_t t);
        int off = int'(t.mar[1:0]);
        if (ref_size(t) == 1) return off;
        if (ref_size(t) == 2) return (off / 2) * 2;
        return 0;
    endfunction

    function automatic bit ref_trap(instr_t t);
`ifdef MISALIGN_TRAP_EN
        int off = int'(t.mar[1:0]);
        if (!is_mem(t)) return 1'b0;
        return (ref_size(t) == 2 && (off % 2) != 0) || (ref_size(t) == 4 && off != 0);
`else
        return (t.lat < 0);
`endif
    endfunction

    function automatic logic [3:0] ref_mask(instr_t t);
        int m = ((1 << ref_size(t)) - 1) << ref_pos(t);
        return 4'(m);
    endfunction

    function automatic logic [31:0] ref_sdata(instr_t t);
        return t.rs2 << (8 * ref_pos(t));
    endfunction

    function automatic logic [31:0] ref_wb(instr_t t);
        logic [31:0] w, b, h;
        w = t.rdata >> (8 * int'(t.mar[1:0]));
        b = w & 32'hFF;
        h = w & 32'hFFFF;
        case (t.sel)
            rf_alu_out:  return t.alu;
            rf_br_en:    return t.br ? 32'd1 : 32'd0;
            rf_u_imm:    return t.uimm;
            rf_pc_plus4: return t.pc + 32'd4;
            rf_lw:       return t.rdata;
            rf_lbu:      return b;
            rf_lb:       return (b >= 32'd128) ? b - 32'd256 : b;
            rf_lhu:      return h;
            rf_lh:       return (h >= 32'h8000) ? h - 32'h10000 : h;
            default:     return 32'd0;
        endcase
    endfunction

    function automatic bit ref_lrf(instr_t t);
        bit w = (t.opc == op_lui || t.opc == op_auipc || t.opc == op_jal || t.opc == op_jalr ||
                 t.opc == op_load || t.opc == op_imm || t.opc == op_reg);
        return t.commit && (t.rd != 5'd0) && w && !ref_trap(t);
    endfunction

    function automatic instr_t mk(rv32i_opcode opc, logic [2:0] f3, regfilemux_sel_t sel,
                                  logic [31:0] mar, logic [31:0] rs2, logic [31:0] rdata,
                                  int lat, int hold);
        instr_t t;
        t.opc = opc; t.f3 = f3; t.sel = sel; t.rd = 5'd9; t.commit = 1'b1;
        t.mar = mar; t.rs2 = rs2; t.rdata = rdata; t.alu = 32'h0A0A0A0A;
        t.uimm = 32'h12345000; t.pc = 32'h00400000; t.br = 1'b1;
        t.lat = lat; t.hold = hold;
        return t;
    endfunction

    function automatic instr_t gen_random();
        instr_t t;
        int k = $urandom_range(0, 11);
        t = mk(op_imm, 3'b000, rf_alu_out, $urandom(), $urandom(), $urandom(),
               $urandom_range(1, 5), $urandom_range(0, 3));
        t.rd = 5'($urandom_range(0, 31));
        t.commit = ($urandom_range(0, 7) != 0);
        t.alu = $urandom(); t.uimm = $urandom() & 32'hFFFFF000;
        t.pc = $urandom() & 32'hFFFFFFFC; t.br = 1'($urandom_range(0, 1));
        case (k)
            0:  begin t.opc = op_load;  t.f3 = 3'b000; t.sel = rf_lb;  end
            1:  begin t.opc = op_load;  t.f3 = 3'b100; t.sel = rf_lbu; end
            2:  begin t.opc = op_load;  t.f3 = 3'b001; t.sel = rf_lh;  end
            3:  begin t.opc = op_load;  t.f3 = 3'b101; t.sel = rf_lhu; end
            4:  begin t.opc = op_load;  t.f3 = 3'b010; t.sel = rf_lw;  end
            5:  begin t.opc = op_store; t.f3 = 3'b000; end
            6:  begin t.opc = op_store; t.f3 = 3'b001; end
            7:  begin t.opc = op_store; t.f3 = 3'b010; end
            8:  begin t.opc = op_lui;   t.sel = rf_u_imm; end
            9:  begin t.opc = op_jal;   t.sel = rf_pc_plus4; end
            10: begin t.opc = op_reg;   t.sel = rf_br_en; end
            default: ;
        endcase
        if (!is_mem(t) || ref_trap(t)) t.lat = 0;
        return t;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(instr_t t);
        control_word_in = '{opcode: t.opc, funct3: t.f3, regfilemux_sel: t.sel, rd: t.rd, pc: t.pc};
        alu_in = t.alu; mar_in = t.mar; mem_wdata_in = t.rs2; br_en_in = t.br;
        imm_in = '0; imm_in.u_imm = t.uimm;
        monitor_in = '0; monitor_in.commit = t.commit; monitor_in.rd_addr = t.rd;
        mem_read_in  = t.commit && t.opc == op_load;
        mem_write_in = t.commit && t.opc == op_store;
    endtask

    task automatic idle_inputs();
        load = 1'b0; bubble = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        dmem_resp = 1'b0; monitor_in = '0; control_word_in = '0;
    endtask

    task automatic exec(input instr_t t, output int n_rd, output int n_wr, output int n_st,
                        output logic [31:0] addr_s, output logic [31:0] wd_s, output logic [3:0] be_s);
        int last = t.lat + t.hold;
        n_rd = 0; n_wr = 0; n_st = 0; addr_s = '0; wd_s = '0; be_s = '0;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            drive(t);
            bubble     = 1'b0;
            dmem_resp  = (c == t.lat);
            dmem_rdata = (c == t.lat) ? t.rdata : $urandom();
            load       = (c < t.lat) || (c == last);
            @(negedge clk);
            if (dmem_read)  n_rd++;
            if (dmem_write) n_wr++;
            if (mem_stall)  n_st++;
            if (c == 0 && (dmem_read || dmem_write)) begin
                addr_s = dmem_address; wd_s = dmem_wdata; be_s = dmem_byte_enable;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs(); rst = 1'b1;
        mem_read_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (dmem_read !== 1'b0 || mem_stall !== 1'b0) begin errors++;
            $display("FAIL reset_strobe: read %b stall %b want 0 0", dmem_read, mem_stall); end
        checks++; if (load_regfile !== 1'b0 || rd_out !== 5'd0 || regfile_wdata !== 32'd0) begin errors++;
            $display("FAIL reset_wb: lrf %b rd %0d wdata %h want 0 0 0", load_regfile, rd_out, regfile_wdata); end
        checks++; if (monitor_out !== '0) begin errors++;
            $display("FAIL reset_monitor: commit %b addr %h want all zero", monitor_out.commit, monitor_out.mem_addr); end
        @(posedge clk); #1; rst = 1'b0; idle_inputs();
    endtask

    task automatic test_directed();
        instr_t t; int nr, nw, ns; logic [31:0] a, wd; logic [3:0] be;
        t = mk(op_load, 3'b010, rf_lw, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0);
        exec(t, nr, nw, ns, a, wd, be);
        checks++; if (nr != 3 || ns != 3) begin errors++;
            $display("FAIL lw_latency: read %0d stall %0d cycles want 3 3", nr, ns); end
        checks++; if (regfile_wdata !== 32'hDEADBEEF || load_regfile !== 1'b1) begin errors++;
            $display("FAIL lw_data: %h lrf %b want deadbeef 1", regfile_wdata, load_regfile); end
        t = mk(op_load, 3'b000, rf_lb, 32'h103, 32'h0, 32'h80123456, 1, 0);
        exec(t, nr, nw, ns, a, wd, be);
        checks++; if (regfile_wdata !== 32'hFFFFFF80) begin errors++;
            $display("FAIL lb_sign: %h want ffffff80", regfile_wdata); end
        t = mk(op_load, 3'b100, rf_lbu, 32'h103, 32'h0, 32'h80123456, 2, 0);
        exec(t, nr, nw, ns, a, wd, be);
        checks++; if (regfile_wdata !== 32'h00000080) begin errors++;
            $display("FAIL lbu_zero: %h want 00000080", regfile_wdata); end
        t = mk(op_store, 3'b001, rf_alu_out, 32'h202, 32'h0000ABCD, 32'h0, 2, 0);
        exec(t, nr, nw, ns, a, wd, be);
        checks++; if (a !== 32'h200 || be !== 4'b1100 || wd !== 32'hABCD0000) begin errors++;
            $display("FAIL sh_format: addr %h be %b data %h want 200 1100 abcd0000", a, be, wd); end
        checks++; if (load_regfile !== 1'b0 || nw != 2 || nr != 0) begin errors++;
            $display("FAIL sh_wb: lrf %b writes %0d reads %0d want 0 2 0", load_regfile, nw, nr); end
    endtask

    task automatic test_hold();
        instr_t t; int nr, nw, ns; logic [31:0] a, wd; logic [3:0] be;
        t = mk(op_load, 3'b010, rf_lw, 32'h100, 32'h0, 32'h11223344, 2, 4);
        exec(t, nr, nw, ns, a, wd, be);
        checks++; if (nr != 2 || ns != 2) begin errors++;
            $display("FAIL hold_single_access: reads %0d stalls %0d want 2 2", nr, ns); end
        checks++; if (regfile_wdata !== 32'h11223344 || load_regfile !== 1'b1) begin errors++;
            $display("FAIL hold_data: %h lrf %b want 11223344 1", regfile_wdata, load_regfile); end
    endtask

    task automatic test_bubble();
        instr_t t, u; int nr, nw, ns; logic [31:0] a, wd; logic [3:0] be;
        t = mk(op_imm, 3'b000, rf_alu_out, 32'h40, 32'h0, 32'h0, 0, 0);
        t.alu = 32'h1234; t.rd = 5'd5;
        exec(t, nr, nw, ns, a, wd, be);
        u = t; u.alu = 32'h9999; u.rd = 5'd7; u.mar = 32'h80;
        drive(u); load = 1'b1; bubble = 1'b1;
        @(posedge clk); #1; idle_inputs();
        checks++; if (load_regfile !== 1'b0 || rd_out !== 5'd0 || monitor_out.commit !== 1'b0) begin errors++;
            $display("FAIL bubble_kill: lrf %b rd %0d commit %b want 0 0 0", load_regfile, rd_out, monitor_out.commit); end
        checks++; if (regfile_wdata !== 32'h1234 || monitor_out.mem_addr !== 32'h40) begin errors++;
            $display("FAIL bubble_hold: wdata %h addr %h want 1234 40", regfile_wdata, monitor_out.mem_addr); end
    endtask

    task automatic test_rst_mid_access();
        instr_t t; int nr, nw, ns; logic [31:0] a, wd; logic [3:0] be;
        t = mk(op_load, 3'b010, rf_lw, 32'h300, 32'h0, 32'h55AA55AA, 9, 0);
        @(posedge clk); #1; drive(t); load = 1'b1; dmem_resp = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (dmem_read !== 1'b1 || mem_stall !== 1'b1) begin errors++;
            $display("FAIL rst_pre_access: read %b stall %b want 1 1", dmem_read, mem_stall); end
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        checks++; if (dmem_read !== 1'b0 || mem_stall !== 1'b0) begin errors++;
            $display("FAIL rst_drop_strobe: read %b stall %b want 0 0", dmem_read, mem_stall); end
        @(posedge clk); #1; rst = 1'b0; idle_inputs(); dmem_resp = 1'b1; dmem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        checks++; if (dmem_read !== 1'b0 || mem_stall !== 1'b0 || monitor_out.commit !== 1'b0) begin errors++;
            $display("FAIL rst_after: read %b stall %b commit %b want 0 0 0", dmem_read, mem_stall, monitor_out.commit); end
        @(posedge clk); #1; dmem_resp = 1'b0;
        t.lat = 1;
        exec(t, nr, nw, ns, a, wd, be);
        checks++; if (nr != 1 || regfile_wdata !== 32'h55AA55AA) begin errors++;
            $display("FAIL rst_recover: reads %0d data %h want 1 55aa55aa", nr, regfile_wdata); end
    endtask

    task automatic test_misalign();
        instr_t t; int nr, nw, ns; logic [31:0] a, wd; logic [3:0] be; bit tr;
        t = mk(op_load, 3'b010, rf_lw, 32'h101, 32'h0, 32'h01020304, 2, 0);
        tr = ref_trap(t);
        if (tr) t.lat = 0;
        exec(t, nr, nw, ns, a, wd, be);
        checks++; if (nr != (tr ? 0 : 2) || monitor_out.trap !== tr) begin errors++;
            $display("FAIL misalign_lw: reads %0d trap %b want %0d %b", nr, monitor_out.trap, tr ? 0 : 2, tr); end
        checks++; if (load_regfile !== !tr) begin errors++;
            $display("FAIL misalign_lrf: %b want %b", load_regfile, !tr); end
        if (!tr) begin
            checks++; if (a !== 32'h100) begin errors++;
                $display("FAIL misalign_addr: %h want 100", a); end
        end
    endtask

    task automatic test_random();
        instr_t t; int nr, nw, ns; logic [31:0] a, wd; logic [3:0] be;
        bit rd_op, wr_op, tr, lrf, data_ok;
        for (int i = 0; i < 60; i++) begin
            t = gen_random();
            exec(t, nr, nw, ns, a, wd, be);
            tr = ref_trap(t);
            rd_op = t.commit && t.opc == op_load && !tr;
            wr_op = t.commit && t.opc == op_store && !tr;
            lrf = ref_lrf(t);
            data_ok = lrf || (t.opc != op_load);
            checks++; if (nr != (rd_op ? t.lat : 0) || nw != (wr_op ? t.lat : 0) || ns != t.lat * (rd_op || wr_op)) begin
                errors++; $display("FAIL rand_strobes[%0d]: r %0d w %0d s %0d want lat %0d rd %b wr %b", i, nr, nw, ns, t.lat, rd_op, wr_op); end
            if (rd_op || wr_op) begin
                checks++; if (a !== {t.mar[31:2], 2'b00} || be !== (wr_op ? ref_mask(t) : 4'b0) || (wr_op && wd !== ref_sdata(t))) begin
                    errors++; $display("FAIL rand_request[%0d]: addr %h be %b data %h want %h %b %h", i, a, be, wd, {t.mar[31:2], 2'b00}, wr_op ? ref_mask(t) : 4'b0, ref_sdata(t)); end
            end
            checks++; if (load_regfile !== lrf || rd_out !== t.rd || monitor_out.commit !== t.commit || monitor_out.trap !== tr) begin
                errors++; $display("FAIL rand_ctrl[%0d]: lrf %b rd %0d commit %b trap %b want %b %0d %b %b", i, load_regfile, rd_out, monitor_out.commit, monitor_out.trap, lrf, t.rd, t.commit, tr); end
            if (data_ok) begin
                checks++; if (regfile_wdata !== ref_wb(t)) begin
                    errors++; $display("FAIL rand_wdata[%0d]: %h want %h", i, regfile_wdata, ref_wb(t)); end
                checks++; if (monitor_out.rd_wdata !== ((t.rd == 5'd0) ? 32'd0 : ref_wb(t))) begin
                    errors++; $display("FAIL rand_rd_wdata[%0d]: %h want %h", i, monitor_out.rd_wdata, (t.rd == 5'd0) ? 32'd0 : ref_wb(t)); end
            end
            checks++; if (monitor_out.mem_addr !== t.mar || monitor_out.mem_rmask !== (rd_op ? ref_mask(t) : 4'b0) ||
                          monitor_out.mem_wmask !== (wr_op ? ref_mask(t) : 4'b0) ||
                          monitor_out.mem_rdata !== (rd_op ? t.rdata : 32'd0) ||
                          monitor_out.mem_wdata !== (wr_op ? ref_sdata(t) : 32'd0)) begin
                errors++; $display("FAIL rand_monitor[%0d]: addr %h rm %b wm %b rdat %h wdat %h", i, monitor_out.mem_addr,
                                   monitor_out.mem_rmask, monitor_out.mem_wmask, monitor_out.mem_rdata, monitor_out.mem_wdata); end
        end
    endtask

    initial begin
        rst = 1'b1; idle_inputs();
        alu_in = '0; mar_in = '0; mem_wdata_in = '0; br_en_in = 1'b0; imm_in = '0; dmem_rdata = '0;
        test_reset();
        test_directed();
        test_hold();
        test_bubble();
        test_rst_mid_access();
        test_misalign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access stage plus MEM/WB pipeline register, directly downstream of the EX/MEM register.
- Issues the single data-memory request for loads and stores and stalls the pipeline until the data-memory response.
- Aligns and sign/zero-extends load data.
- Registers the writeback control, data and monitor fields that feed the register file and the RVFI monitor.

Parameters:
- none (widths fixed by rv32i_types: XLEN 32, 4-bit byte mask)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- load  in  1  advance MEM/WB register (global pipeline enable)
- bubble  in  1  insert NOP into MEM/WB on load
- control_word_in  in  rv32i_control_word  EX/MEM control word
- alu_in  in  32  ALU result from EX/MEM
- mar_in  in  32  byte address from EX/MEM
- mem_wdata_in  in  32  store data (unshifted rs2)
- mem_read_in  in  1  load request (already gated by commit)
- mem_write_in  in  1  store request (already gated by commit)
- br_en_in  in  1  compare result
- imm_in  in  packed_imm  immediates
- monitor_in  in  monitor_t  monitor record from EX/MEM
- dmem_resp  in  1  data-memory response, 1-cycle pulse
- dmem_rdata  in  32  data-memory read word
- dmem_read  out  1  read strobe
- dmem_write  out  1  write strobe
- dmem_address  out  32  word-aligned address
- dmem_wdata  out  32  byte-lane-shifted store data
- dmem_byte_enable  out  4  store byte mask
- mem_stall  out  1  hold all upstream stages
- load_regfile  out  1  register-file write enable
- rd_out  out  5  destination register
- regfile_wdata  out  32  writeback data
- monitor_out  out  monitor_t  committed monitor record

Behaviour:
Reset:
- FSM goes to IDLE; dmem_read, dmem_write and mem_stall are 0.
- All MEM/WB registers clear: control word opcode 0, rd 0, commit 0; load_regfile 0, regfile_wdata 0, monitor_out all zero.

FSM (states IDLE, ACCESS, DONE):
- IDLE → ACCESS when mem_read_in | mem_write_in. The transition is combinational: strobes assert in the same cycle the instruction arrives.
- ACCESS:
  - dmem_read = mem_read_in, dmem_write = mem_write_in, held until dmem_resp.
  - dmem_address = {mar_in[31:2],2'b00}.
  - mem_stall = 1 until dmem_resp.
  - On dmem_resp: capture dmem_rdata into rdata_hold, go to DONE.
- DONE:
  - No strobes; mem_stall = 0.
  - Stays in DONE while load = 0, so an external stall never causes a second access.
  - On load = 1 → IDLE.
- If dmem_resp and load arrive in the same cycle, write MEM/WB using dmem_rdata directly and go to IDLE.
- Minimum memory latency: 1 cycle after the strobe.

Store formatting:
- sw: mask 1111.
- sh: mask 0011 << {mar[1],0}; data shifted by 16*mar[1].
- sb: mask 0001 << mar[1:0]; data shifted by 8*mar[1:0].
- dmem_byte_enable = 0 on reads.

Load extraction (from the word, shifted by mar[1:0]):
- lb/lbu: byte, sign/zero-extended.
- lh/lhu: halfword, sign/zero-extended.
- lw: full word.

Writeback data select (by regfilemux_sel):
- alu_out → alu_in
- br_en → zero-extended br_en_in
- u_imm → imm_in.u_imm
- lw/lb/lbu/lh/lhu → extracted load data
- pc_plus4 → control_word_in.pc + 4

MEM/WB register update:
- On load & ~mem_stall: register control word, regfile_wdata and monitor.
  - load_regfile = monitor_in.commit & (rd != 0) & opcode ∈ {op_lui, op_auipc, op_jal, op_jalr, op_load, op_imm, op_reg}.
  - Monitor fill: mem_addr = mar_in, mem_rmask/mem_wmask from the byte mask, mem_rdata = raw word, mem_wdata = shifted store data, rd_wdata = regfile_wdata or 0 when rd = 0.
- On load & bubble: commit 0, load_regfile 0, rd 0; all other fields unchanged.
- When load = 0 or mem_stall = 1: hold all registers.

Boundaries:
- rst during ACCESS drops the strobes immediately; a late dmem_resp is ignored in IDLE.
- Instruction with commit = 0 never issues (request inputs are already gated).

Optional Feature:
Macro MISALIGN_TRAP_EN.
- Defined: a lh/lhu/sh with mar[0] = 1, or a lw/sw with mar[1:0] ≠ 0, issues no access (FSM stays IDLE). It sets monitor.trap = 1 and forces load_regfile = 0.
- Undefined: the low address bits are ignored for the word address and the access proceeds with the computed mask.

Decomposition:
- Package rv32i_types gains mem_fsm_state_t (IDLE, ACCESS, DONE); it reuses load_funct3_t, store_funct3_t, regfilemux_sel_t and monitor_t.
- One sub-module, mem_align: combinational store shift/mask and load extract/extend. It is shared with the monitor checker.

Test Plan:
- lw, mar 0x100, dmem_rdata 0xDEADBEEF, resp after 3 cycles → dmem_read high 3 cycles; mem_stall high 3 cycles; regfile_wdata 0xDEADBEEF; load_regfile 1.
- lb, mar 0x103, rdata 0x80123456 → regfile_wdata 0xFFFFFF80; lbu → 0x00000080.
- sh, mar 0x202, rs2 0x0000ABCD → dmem_address 0x200, byte_enable 1100, wdata 0xABCD0000; load_regfile 0.
- lw completes (resp) but load held low 4 cycles → exactly one dmem_read pulse sequence; DONE held; data written when load rises.
- rst asserted mid-ACCESS → next cycle dmem_read 0, mem_stall 0, monitor_out.commit 0.
- With MISALIGN_TRAP_EN defined, lw at mar 0x101 → no strobe; monitor.trap 1; load_regfile 0.
